// File: rtl/alu_pipe.sv
// Pipelined ALU with a registered result, valid/ready handshakes on both sides,
// and an iterative shift-add multiplier that takes WIDTH cycles per MUL.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             is_zero,
    output logic             carry,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                 accept;
    logic                 is_mul;
    logic                 mul_last;
    logic [WIDTH-1:0]     alu_rd;
    logic                 alu_c;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        count;
    logic                 mul_zero;

    // Valid/ready contract: a transfer happens on a rising edge where valid and
    // ready are both 1. The producer holds opcode/rs1/rs2 stable while in_valid=1
    // and in_ready=0; this block holds rd/is_zero/carry while out_valid=1 and
    // out_ready=0. in_ready looks at out_ready so a full output register can be
    // drained and refilled on the same edge.
    assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (opcode == OP_MUL);
    assign mul_last = (state_q == S_MUL) && (count == LAST);
    assign busy     = (state_q == S_MUL);

    always_comb begin
        alu_rd = '0;
        alu_c  = 1'b0;
        case (opcode)
            OP_PASS: alu_rd = rs1;
            OP_SUB:  {alu_c, alu_rd} = {1'b0, rs1} - {1'b0, rs2};
            OP_ADD:  {alu_c, alu_rd} = {1'b0, rs1} + {1'b0, rs2};
            OP_AND:  alu_rd = rs1 & rs2;
            OP_XOR:  alu_rd = rs1 ^ rs2;
            OP_OR:   alu_rd = rs1 | rs2;
            OP_SHL:  alu_rd = rs1 << rs2[SHW-1:0];
            // MUL goes through the FSM; with MUL_EN=0 this opcode yields zero.
            default: alu_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_mul) state_d = S_MUL;
            S_MUL:  if (count == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // One multiplier bit per cycle, LSB first; the multiplicand is pre-widened so
    // the full 2*WIDTH product is available for the overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            mul_zero <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (accept && is_mul) begin
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, rs1};
                mplier   <= rs2;
                count    <= '0;
                mul_zero <= (rs1 == '0);
            end
        end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rd        <= '0;
            is_zero   <= 1'b0;
            carry     <= 1'b0;
        end else if (mul_last) begin
            out_valid <= 1'b1;
            rd        <= acc_next[WIDTH-1:0];
            carry     <= |acc_next[2*WIDTH-1:WIDTH];
            is_zero   <= mul_zero;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            rd        <= alu_rd;
            carry     <= alu_c;
            is_zero   <= (rs1 == '0);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed ALU/MUL vectors, backpressure,
// reset during a multiply, a MUL_EN=0 build and a random scoreboard run.
module tb_alu_pipe;

    localparam int W = 8;
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, is_zero, carry, busy;
    logic [2:0]   opcode;
    logic [W-1:0] rs1, rs2, rd;

    logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_is_zero, n_carry, n_busy;
    logic [2:0]   n_opcode;
    logic [W-1:0] n_rs1, n_rs2, n_rd;

    logic [W+1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .out_valid(out_valid),
        .out_ready(out_ready), .rd(rd), .is_zero(is_zero), .carry(carry), .busy(busy)
    );

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .opcode(n_opcode), .rs1(n_rs1), .rs2(n_rs2), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .rd(n_rd), .is_zero(n_is_zero), .carry(n_carry), .busy(n_busy)
    );

    // reference model, packed as {rd, is_zero, carry}
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W:0]     s;
        logic [W-1:0]   r;
        logic           c;
        c = 1'b0;
        r = '0;
        case (op)
            OP_PASS: r = a;
            OP_SUB:  begin r = a - b; c = (a < b); end
            OP_ADD:  begin s = a + b; r = s[W-1:0]; c = s[W]; end
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_SHL:  r = a << b[2:0];
            default: begin p = a * b; r = p[W-1:0]; c = (p[2*W-1:W] != '0); end
        endcase
        return {r, (a == '0), c};
    endfunction

    // driver: present an op, hold it until accepted, optionally push its expected result
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+1:0] exp, input bit push);
        int n;
        opcode   = op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({out_valid, rd, is_zero, carry, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b rd=%h z=%b c=%b busy=%b, required all 0",
                     out_valid, rd, is_zero, carry, busy);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        total++;
        if ({n_out_valid, n_rd, n_busy} !== '0) begin
            bad++;
            $display("FAIL reset_nomul: got ov=%b rd=%h busy=%b, required 0", n_out_valid, n_rd, n_busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [2:0]   ops[12] = '{OP_ADD, OP_SUB, OP_AND, OP_SHL, OP_PASS, OP_XOR,
                                  OP_OR, OP_SUB, OP_ADD, OP_SHL, OP_PASS, OP_SUB};
        logic [W-1:0] as[12]  = '{8'hF0, 8'h05, 8'h00, 8'h01, 8'h5A, 8'hA5,
                                  8'h50, 8'h07, 8'h7F, 8'h81, 8'h00, 8'h00};
        logic [W-1:0] bs[12]  = '{8'h20, 8'h07, 8'hFF, 8'h0B, 8'h33, 8'h0F,
                                  8'h0A, 8'h05, 8'h01, 8'h07, 8'hFF, 8'h01};
        logic [W+1:0] es[12]  = '{{8'h10, 1'b0, 1'b1}, {8'hFE, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0},
                                  {8'h08, 1'b0, 1'b0}, {8'h5A, 1'b0, 1'b0}, {8'hAA, 1'b0, 1'b0},
                                  {8'h5A, 1'b0, 1'b0}, {8'h02, 1'b0, 1'b0}, {8'h80, 1'b0, 1'b0},
                                  {8'h80, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0}, {8'hFF, 1'b1, 1'b1}};
        logic [W+1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(ops[i], as[i], bs[i], es[i], 1'b1);
            @(negedge clk);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            total++;
            if (out_valid !== 1'b1 || {rd, is_zero, carry} !== exp) begin
                bad++;
                $display("FAIL single_op%0d: got ov=%b {rd,z,c}=%h, required ov=1 %h",
                         i, out_valid, {rd, is_zero, carry}, exp);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL consume_drop: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic [W-1:0] as[5] = '{8'h0D, 8'hC8, 8'hFF, 8'h00, 8'h10};
        logic [W-1:0] bs[5] = '{8'h0B, 8'h03, 8'hFF, 8'h37, 8'h10};
        logic [W+1:0] es[5] = '{{8'h8F, 1'b0, 1'b0}, {8'h58, 1'b0, 1'b1}, {8'h01, 1'b0, 1'b1},
                                {8'h00, 1'b1, 1'b0}, {8'h00, 1'b0, 1'b1}};
        logic [W+1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(OP_MUL, as[i], bs[i], es[i], 1'b1);
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                total++;
                if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL mul%0d_cycle%0d: got busy=%b in_ready=%b ov=%b, required 1 0 0",
                             i, c, busy, in_ready, out_valid);
                end
            end
            @(negedge clk);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || {rd, is_zero, carry} !== exp) begin
                bad++;
                $display("FAIL mul%0d_result: got ov=%b busy=%b {rd,z,c}=%h, required ov=1 busy=0 %h",
                         i, out_valid, busy, {rd, is_zero, carry}, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[4] = '{OP_OR, OP_SUB, OP_XOR, OP_ADD};
        logic [W-1:0] as[4]  = '{8'h0F, 8'h10, 8'hFF, 8'hFF};
        logic [W-1:0] bs[4]  = '{8'hF0, 8'h01, 8'hFF, 8'h02};
        logic [W+1:0] es[4]  = '{{8'hFF, 1'b0, 1'b0}, {8'h0F, 1'b0, 1'b0},
                                 {8'h00, 1'b0, 1'b0}, {8'h01, 1'b0, 1'b1}};
        logic [W+1:0] exp;
        out_ready = 1'b0;
        send(OP_ADD, 8'h01, 8'h01, {8'h02, 1'b0, 1'b0}, 1'b1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {rd, is_zero, carry} !== exp) begin
                bad++;
                $display("FAIL stall%0d: got ov=%b in_ready=%b {rd,z,c}=%h, required ov=1 in_ready=0 %h",
                         c, out_valid, in_ready, {rd, is_zero, carry}, exp);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode   = ops[i];
            rs1      = as[i];
            rs2      = bs[i];
            in_valid = 1'b1;
            exp_q.push_back(es[i]);
            @(negedge clk);
            if (i > 0) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                total++;
                if (out_valid !== 1'b1 || {rd, is_zero, carry} !== exp) begin
                    bad++;
                    $display("FAIL b2b_res%0d: got ov=%b {rd,z,c}=%h, required ov=1 %h",
                             i - 1, out_valid, {rd, is_zero, carry}, exp);
                end
            end
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready%0d: in_ready=%b, required 1", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        total++;
        if (out_valid !== 1'b1 || {rd, is_zero, carry} !== exp) begin
            bad++;
            $display("FAIL b2b_res3: got ov=%b {rd,z,c}=%h, required ov=1 %h",
                     out_valid, {rd, is_zero, carry}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        logic [W+1:0] exp;
        out_ready = 1'b1;
        send(OP_MUL, 8'h0D, 8'h0B, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 8'h00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_reset: got ov=%b busy=%b rd=%h in_ready=%b, required 0 0 00 1",
                     out_valid, busy, rd, in_ready);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL aborted_mul%0d: got ov=%b busy=%b, required 0 0", c, out_valid, busy);
            end
        end
        @(posedge clk);
        #1;
        send(OP_ADD, 8'h03, 8'h04, {8'h07, 1'b0, 1'b0}, 1'b1);
        @(negedge clk);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        total++;
        if (out_valid !== 1'b1 || {rd, is_zero, carry} !== exp) begin
            bad++;
            $display("FAIL post_reset_add: got ov=%b {rd,z,c}=%h, required ov=1 %h",
                     out_valid, {rd, is_zero, carry}, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul_disabled();
        logic [2:0]   ops[3] = '{OP_MUL, OP_ADD, OP_MUL};
        logic [W-1:0] as[3]  = '{8'hFF, 8'hF0, 8'h00};
        logic [W-1:0] bs[3]  = '{8'h03, 8'h20, 8'h05};
        logic [W+1:0] es[3]  = '{{8'h00, 1'b0, 1'b0}, {8'h10, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0}};
        n_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_opcode   = ops[i];
            n_rs1      = as[i];
            n_rs2      = bs[i];
            n_in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (n_in_ready !== 1'b1) begin
                bad++;
                $display("FAIL nomul_ready%0d: in_ready=%b, required 1", i, n_in_ready);
            end
            @(posedge clk);
            #1;
            n_in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (n_out_valid !== 1'b1 || n_busy !== 1'b0 || {n_rd, n_is_zero, n_carry} !== es[i]) begin
                bad++;
                $display("FAIL nomul_op%0d: got ov=%b busy=%b {rd,z,c}=%h, required ov=1 busy=0 %h",
                         i, n_out_valid, n_busy, {n_rd, n_is_zero, n_carry}, es[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0]   op;
                    logic [W-1:0] a, b;
                    op = 3'($urandom_range(0, 7));
                    a  = 8'($urandom_range(0, 255));
                    b  = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 4) == 0) a = '0;
                    send(op, a, b, model(op, a, b), 1'b1);
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                int got_n;
                int cyc;
                logic [W+1:0] exp;
                got_n = 0;
                cyc   = 0;
                while (got_n < 40 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                        total++;
                        if ({rd, is_zero, carry} !== exp) begin
                            bad++;
                            $display("FAIL random_res%0d: got {rd,z,c}=%h, required %h",
                                     got_n, {rd, is_zero, carry}, exp);
                        end
                        got_n++;
                    end
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                total++;
                if (got_n != 40) begin
                    bad++;
                    $display("FAIL random_count: got %0d results, required 40", got_n);
                end
                out_ready = 1'b1;
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_valid    = 1'b0;
        opcode      = '0;
        rs1         = '0;
        rs2         = '0;
        out_ready   = 1'b1;
        n_in_valid  = 1'b0;
        n_opcode    = '0;
        n_rs1       = '0;
        n_rs2       = '0;
        n_out_ready = 1'b1;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_mul_disabled();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: %0d results never produced, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
